// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, LCR field indices and parity helper
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1  = 3'd4;
    localparam logic [2:0] ST_STOP15 = 3'd5;
    localparam logic [2:0] ST_STOP2  = 3'd6;

    localparam int LCR_WLS = 0;
    localparam int LCR_STB = 2;
    localparam int LCR_PEN = 3;
    localparam int LCR_EPS = 4;
    localparam int LCR_SP  = 5;
    localparam int LCR_BC  = 6;

    localparam logic [1:0] WL_5 = 2'b00;
    localparam logic [1:0] WL_6 = 2'b01;
    localparam logic [1:0] WL_7 = 2'b10;
    localparam logic [1:0] WL_8 = 2'b11;

    // Stick parity overrides the data: even-select then forces the bit low.
    function automatic logic uart_parity(input logic [7:0] data, input logic [1:0] wl,
                                         input logic even, input logic stick);
        logic [7:0] mask;
        mask = 8'hFF;
        case (wl)
            WL_5: mask = 8'h1F;
            WL_6: mask = 8'h3F;
            WL_7: mask = 8'h7F;
            WL_8: mask = 8'hFF;
        endcase
        if (stick)
            return ~even;
        return even ? ^(data & mask) : ~^(data & mask);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmit serializer fed from the TX FIFO show-ahead port
module uart_tx
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enable,
    input  logic [7:0] lcr,
    input  logic       tf_empty,
    input  logic [7:0] tf_data_in,
    output logic       tf_pop,
    output logic       tx_out,
    output logic       tx_busy,
    output logic [2:0] tx_state
);

    localparam int TW = $clog2(TICKS_PER_BIT);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(TICKS_PER_BIT / 2 - 1);

    logic [2:0]    state, state_nx;
    logic [TW-1:0] tick, tick_nx;
    logic [2:0]    bit_cnt, bit_nx;
    logic [7:0]    shift, shift_nx;
    logic [7:0]    data_q, data_nx;
    logic [5:0]    cfg, cfg_nx;
    logic [2:0]    wl_last;
    logic          bit_end;
    logic          tx_nx;
    logic          unused_lcr;

    assign unused_lcr = lcr[7];

    // Last data bit index is WL-1 = 4 + word-length code.
    assign wl_last = {1'b0, cfg[LCR_WLS +: 2]} + 3'd4;
    assign bit_end = enable && (state != ST_IDLE) &&
                     (tick == ((state == ST_STOP15) ? HALF_LAST : TICK_LAST));

    // Gated by rstn so a reset cycle can never consume a FIFO entry.
    assign tf_pop = rstn && (state == ST_IDLE) && enable && !tf_empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            data_q  <= '0;
            cfg     <= '0;
            tx_out  <= 1'b1;
        end else begin
            state   <= state_nx;
            tick    <= tick_nx;
            bit_cnt <= bit_nx;
            shift   <= shift_nx;
            data_q  <= data_nx;
            cfg     <= cfg_nx;
            tx_out  <= tx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tick_nx  = tick;
        bit_nx   = bit_cnt;
        shift_nx = shift;
        data_nx  = data_q;
        cfg_nx   = cfg;
        if (state != ST_IDLE && enable)
            tick_nx = bit_end ? '0 : tick + TW'(1);
        case (state)
            ST_IDLE: begin
                if (tf_pop) begin
                    state_nx = ST_START;
                    shift_nx = tf_data_in;
                    data_nx  = tf_data_in;
                    cfg_nx   = lcr[5:0];
                    bit_nx   = '0;
                    tick_nx  = '0;
                end
            end
            ST_START: begin
                if (bit_end)
                    state_nx = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_nx = shift >> 1;
                    if (bit_cnt == wl_last) begin
                        bit_nx   = '0;
                        state_nx = cfg[LCR_PEN] ? ST_PARITY : ST_STOP1;
                    end else begin
                        bit_nx = bit_cnt + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end)
                    state_nx = ST_STOP1;
            end
            ST_STOP1: begin
                if (bit_end) begin
                    if (!cfg[LCR_STB])
                        state_nx = ST_IDLE;
                    else if (cfg[LCR_WLS +: 2] == WL_5)
                        state_nx = ST_STOP15;
                    else
                        state_nx = ST_STOP2;
                end
            end
            ST_STOP15, ST_STOP2: begin
                if (bit_end)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Line level is registered from the next state; break is applied live.
    always_comb begin
        tx_busy  = (state != ST_IDLE);
        tx_state = state;
        case (state_nx)
            ST_START:  tx_nx = 1'b0;
            ST_DATA:   tx_nx = shift_nx[0];
            ST_PARITY: tx_nx = uart_parity(data_q, cfg[LCR_WLS +: 2], cfg[LCR_EPS], cfg[LCR_SP]);
            default:   tx_nx = 1'b1;
        endcase
        if (lcr[LCR_BC])
            tx_nx = 1'b0;
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rstn, enable, tf_empty, tf_pop, tx_out, tx_busy;
    logic [7:0] lcr, tf_data_in;
    logic [2:0] tx_state;

    logic [7:0] fifo_mem [0:15];
    logic [3:0] wr_ptr = 4'd0;
    logic [3:0] rd_ptr = 4'd0;

    int checks = 0;
    int failures = 0;

    logic       tx_log   [0:399];
    logic       pop_log  [0:399];
    logic       busy_log [0:399];
    logic [2:0] st_log   [0:399];

    always #5 clk = ~clk;

    assign tf_empty   = (rd_ptr == wr_ptr);
    assign tf_data_in = fifo_mem[rd_ptr];

    always @(posedge clk) begin
        if (tf_pop)
            rd_ptr <= rd_ptr + 4'd1;
    end

    uart_tx #(.TICKS_PER_BIT(16)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .lcr(lcr),
        .tf_empty(tf_empty), .tf_data_in(tf_data_in), .tf_pop(tf_pop),
        .tx_out(tx_out), .tx_busy(tx_busy), .tx_state(tx_state)
    );

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    // Sample index 0 is the cycle in which the pop is expected.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            tx_log[i]   = tx_out;
            pop_log[i]  = tf_pop;
            busy_log[i] = tx_busy;
            st_log[i]   = tx_state;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; enable = 1'b1; lcr = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_state !== 3'd0 || tf_pop !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: tx_out=%b busy=%b state=%0d pop=%b, expected 1 0 0 0",
                     tx_out, tx_busy, tx_state, tf_pop);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_8n1();
        logic [9:0] exp;
        int npop, nbusy;
        exp = 10'b1101001010;
        lcr = 8'h03; enable = 1'b0;
        push(8'hA5);
        repeat (3) begin
            #1;
            checks++;
            if (tf_pop !== 1'b0 || tx_busy !== 1'b0) begin
                failures++;
                $display("FAIL enable_hold: pop=%b busy=%b, expected 0 0", tf_pop, tx_busy);
            end
            @(negedge clk);
        end
        enable = 1'b1;
        capture(180);
        npop = 0; nbusy = 0;
        for (int i = 0; i < 180; i++) begin
            if (pop_log[i] === 1'b1) npop++;
            if (busy_log[i] === 1'b1) nbusy++;
        end
        checks++;
        if (pop_log[0] !== 1'b1 || npop != 1) begin
            failures++;
            $display("FAIL 8n1_pop: first=%b count=%0d, expected 1 and 1", pop_log[0], npop);
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (tx_log[1 + 16*k] !== exp[k] || tx_log[16 + 16*k] !== exp[k]) begin
                failures++;
                $display("FAIL 8n1_bit%0d: got %b/%b expected %b", k,
                         tx_log[1 + 16*k], tx_log[16 + 16*k], exp[k]);
            end
        end
        checks++;
        if (nbusy != 160 || busy_log[161] !== 1'b0 || st_log[161] !== 3'd0) begin
            failures++;
            $display("FAIL 8n1_busy: busy_cycles=%0d end_busy=%b end_state=%0d, expected 160 0 0",
                     nbusy, busy_log[161], st_log[161]);
        end
    endtask

    // Upper bits of 0xF3 are set so including them would flip the parity.
    task automatic test_5e1();
        logic [7:0] exp;
        exp = 8'b11100110;
        lcr = 8'h18;
        push(8'hF3);
        capture(140);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (tx_log[1 + 16*k] !== exp[k] || tx_log[16 + 16*k] !== exp[k]) begin
                failures++;
                $display("FAIL 5e1_bit%0d: got %b/%b expected %b", k,
                         tx_log[1 + 16*k], tx_log[16 + 16*k], exp[k]);
            end
        end
        checks++;
        if (st_log[104] !== 3'd3) begin
            failures++;
            $display("FAIL 5e1_parity_state: got %0d expected 3", st_log[104]);
        end
        checks++;
        if (busy_log[128] !== 1'b1 || busy_log[129] !== 1'b0) begin
            failures++;
            $display("FAIL 5e1_busy_end: got %b%b expected 10", busy_log[128], busy_log[129]);
        end
    endtask

    task automatic test_5n15();
        int nstop;
        lcr = 8'h04;
        push(8'h00);
        capture(130);
        nstop = 0;
        for (int i = 0; i < 130; i++)
            if ((st_log[i] === 3'd4 || st_log[i] === 3'd5) && tx_log[i] === 1'b1) nstop++;
        checks++;
        if (tx_log[96] !== 1'b0 || tx_log[97] !== 1'b1) begin
            failures++;
            $display("FAIL 5n15_edge: got %b%b expected 01", tx_log[96], tx_log[97]);
        end
        checks++;
        if (nstop != 24) begin
            failures++;
            $display("FAIL 5n15_stop_len: got %0d expected 24", nstop);
        end
        checks++;
        if (st_log[113] !== 3'd5 || busy_log[120] !== 1'b1 || busy_log[121] !== 1'b0) begin
            failures++;
            $display("FAIL 5n15_half: state=%0d busy=%b%b expected 5 and 10",
                     st_log[113], busy_log[120], busy_log[121]);
        end
    endtask

    task automatic test_back_to_back();
        int npop, consec, p0, p1;
        lcr = 8'h07;
        push(8'h55);
        push(8'h0F);
        capture(370);
        npop = 0; consec = 0; p0 = -1; p1 = -1;
        for (int i = 0; i < 370; i++) begin
            if (pop_log[i] === 1'b1) begin
                if (npop == 0) p0 = i;
                if (npop == 1) p1 = i;
                npop++;
                if (i > 0 && pop_log[i-1] === 1'b1) consec++;
            end
        end
        checks++;
        if (npop != 2 || p0 != 0 || p1 != 177) begin
            failures++;
            $display("FAIL b2b_pop_times: count=%0d at %0d,%0d expected 2 at 0,177", npop, p0, p1);
        end
        checks++;
        if (consec != 0) begin
            failures++;
            $display("FAIL b2b_consecutive: got %0d expected 0", consec);
        end
        checks++;
        if (tx_log[24] !== 1'b1 || tx_log[40] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first_data: got %b%b expected 10", tx_log[24], tx_log[40]);
        end
        checks++;
        if (st_log[168] !== 3'd6 || tx_log[168] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_stop2: state=%0d tx=%b expected 6 1", st_log[168], tx_log[168]);
        end
        checks++;
        if (st_log[177] !== 3'd0 || tx_log[177] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gap: state=%0d tx=%b expected 0 1", st_log[177], tx_log[177]);
        end
        checks++;
        if (tx_log[201] !== 1'b1 || tx_log[265] !== 1'b0 || busy_log[354] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_frame: got %b%b busy_end=%b expected 10 0",
                     tx_log[201], tx_log[265], busy_log[354]);
        end
    endtask

    task automatic test_empty_break();
        int bad;
        lcr = 8'h00;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (tf_pop !== 1'b0 || tx_out !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL empty_idle: bad_cycles=%0d expected 0", bad);
        end
        lcr = 8'h40;
        @(negedge clk); #1;
        checks++;
        if (tx_out !== 1'b0 || tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL break_set: tx=%b busy=%b expected 0 0", tx_out, tx_busy);
        end
        lcr = 8'h00;
        @(negedge clk); #1;
        checks++;
        if (tx_out !== 1'b1) begin
            failures++;
            $display("FAIL break_clear: got %b expected 1", tx_out);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        logic [9:0] exp;
        logic [3:0] rd_save;
        int npop;
        exp = 10'b1001111000;
        lcr = 8'h03;
        push(8'hFF);
        capture(70);
        checks++;
        if (st_log[69] !== 3'd2 || tx_log[69] !== 1'b1) begin
            failures++;
            $display("FAIL midframe_setup: state=%0d tx=%b expected 2 1", st_log[69], tx_log[69]);
        end
        push(8'h3C);
        rstn = 1'b0;
        #1;
        rd_save = rd_ptr;
        checks++;
        if (tf_pop !== 1'b0) begin
            failures++;
            $display("FAIL midframe_pop_in_reset: got %b expected 0", tf_pop);
        end
        @(negedge clk); #1;
        checks++;
        if (tx_out !== 1'b1 || tx_state !== 3'd0 || tx_busy !== 1'b0 || rd_ptr !== rd_save) begin
            failures++;
            $display("FAIL midframe_after_reset: tx=%b state=%0d busy=%b rd=%0d expected 1 0 0 %0d",
                     tx_out, tx_state, tx_busy, rd_ptr, rd_save);
        end
        rstn = 1'b1;
        capture(170);
        npop = 0;
        for (int i = 0; i < 170; i++)
            if (pop_log[i] === 1'b1) npop++;
        checks++;
        if (pop_log[0] !== 1'b1 || npop != 1) begin
            failures++;
            $display("FAIL midframe_next_pop: first=%b count=%0d expected 1 1", pop_log[0], npop);
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (tx_log[1 + 16*k] !== exp[k] || tx_log[16 + 16*k] !== exp[k]) begin
                failures++;
                $display("FAIL midframe_bit%0d: got %b/%b expected %b", k,
                         tx_log[1 + 16*k], tx_log[16 + 16*k], exp[k]);
            end
        end
    endtask

    initial begin
        rstn = 1'b0; enable = 1'b0; lcr = 8'h00;
        @(negedge clk);
        test_reset();
        test_8n1();
        test_5e1();
        test_5n15();
        test_back_to_back();
        test_empty_break();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Transmit serializer for the UART master core. It sits directly downstream of the 16-deep TX FIFO.
- Pops bytes from the FIFO's show-ahead read port.
- Frames each byte per the Line Control Register (LCR): start bit, 5–8 data bits LSB first, optional parity, 1/1.5/2 stop bits.
- Drives the serial line at the rate of an externally generated oversampling enable.

Parameters:
TICKS_PER_BIT, 16, enable pulses per bit period; must be even (1.5-stop uses TICKS_PER_BIT*3/2).

Ports:
clk  input  1  system clock
rstn  input  1  synchronous, active-low reset
enable  input  1  one-clk baud-rate pulse (TICKS_PER_BIT pulses per bit)
lcr  input  8  line control: [1:0] word length (00=5,01=6,10=7,11=8), [2] stop select, [3] parity enable, [4] even parity, [5] stick parity, [6] break, [7] unused
tf_empty  input  1  TX FIFO empty
tf_data_in  input  8  TX FIFO head data (valid whenever tf_empty=0)
tf_pop  output  1  one-cycle pop strobe to TX FIFO
tx_out  output  1  serial line, idle high
tx_busy  output  1  high whenever state != IDLE
tx_state  output  3  current state encoding, for status/debug

Behaviour:
- Reset (rstn=0 at posedge):
  - state=IDLE, tick/bit counters=0, shift reg=0, latched LCR=0.
  - tx_out=1, tf_pop=0, tx_busy=0.
  - Applies mid-frame as well: line returns high on the next clock and the partially sent byte is abandoned, with no extra pop.
- States:
  - IDLE
  - START
  - DATA
  - PARITY
  - STOP1
  - STOP15 (the extra half bit)
  - STOP2
- Tick counter:
  - 0..TICKS_PER_BIT-1, advances only on enable.
  - A bit ends on an enable with counter=TICKS_PER_BIT-1; counter wraps to 0.
- IDLE:
  - If enable=1 and tf_empty=0: tf_pop=1 combinationally for that cycle only.
  - Same cycle: latch tf_data_in into the shift reg and latch lcr[5:0] into frame config.
  - Next state START.
  - tf_pop is never asserted outside this condition and never on consecutive cycles.
- START: tx_out=0 for one bit.
- DATA:
  - tx_out = shift[0]; shift right at each bit end.
  - Bit counter counts to WL-1, where WL = 5 + latched lcr[1:0].
  - Then go to PARITY if parity enabled, else STOP1.
- PARITY bit value:
  - stick=0, even=1: XOR of the WL data bits.
  - stick=0, even=0: XNOR of the WL data bits.
  - stick=1, even=1: 0.
  - stick=1, even=0: 1.
  - Unused upper bits (WL<8) are excluded.
- STOP1: tx_out=1 for one bit, then:
  - lcr[2]=0: go to IDLE.
  - lcr[2]=1 and WL=5: go to STOP15, tx_out=1 for TICKS_PER_BIT/2 enables, then IDLE.
  - lcr[2]=1 and WL>5: go to STOP2, one full bit, then IDLE.
- Back-to-back frames:
  - Returning to IDLE on the last stop-bit enable does not pop in that same cycle.
  - The next pop occurs on the next enable if tf_empty=0, giving exactly one tick of idle gap.
- Break (live, unlatched):
  - lcr[6]=1 forces tx_out=0 regardless of state; the FSM keeps running.
  - Clearing break restores tx_out on the next clock.
- Latching rule: LCR changes other than break take effect at the next frame only.
- tx_out is registered; tx_busy and tx_state are derived from the state register.
- enable=0: all counters and state hold.

Decomposition:
- Package uart_pkg, shared with the RX side and the register block:
  - State encoding localparams.
  - LCR bit-index constants (LCR_WLS, LCR_STB, LCR_PEN, LCR_EPS, LCR_SP, LCR_BC).
  - Word-length codes.
- Single module. Parity is a small function in uart_pkg (uart_parity(data, wl, even, stick)) so the RX checker reuses it; no sub-module.

Test Plan:
- 8N1 (lcr=0x03), FIFO holds 0xA5, enable every clk:
  - One tf_pop.
  - tx_out per 16-tick bit: 0,1,0,1,0,0,1,0,1,1.
  - Then IDLE, tx_busy falls after 160 enables.
- 5-bit even parity (lcr=0x18), data 0x13:
  - Bits 0,1,1,0,0,1, parity=1, stop=1.
  - Upper data bits ignored.
- 5-bit 1.5 stop (lcr=0x04), data 0x00:
  - Stop high for exactly 24 enables.
- Two bytes 0x55, 0x0F queued, 8N2 (lcr=0x07):
  - Second tf_pop exactly one enable after the second stop bit ends.
  - tf_pop never 2 consecutive clks.
- tf_empty=1 throughout:
  - tf_pop=0, tx_out=1, tx_busy=0.
  - Set lcr[6] → tx_out=0 next clk; clear → 1.
- rstn=0 during DATA bit 3 of 0xFF:
  - Next clk tx_out=1, state=IDLE, no pop that cycle.
  - Subsequent frame transmits cleanly.
